// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: data/register widths, ALU control
// encodings and the EX control bundle carried through ID/EX.
package mips_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned ALUC_W = 4;

    // ALU control encodings (classic MIPS ALU-control values)
    localparam logic [ALUC_W-1:0] ALU_AND = 4'd0;
    localparam logic [ALUC_W-1:0] ALU_OR  = 4'd1;
    localparam logic [ALUC_W-1:0] ALU_ADD = 4'd2;
    localparam logic [ALUC_W-1:0] ALU_SUB = 4'd6;
    localparam logic [ALUC_W-1:0] ALU_SLT = 4'd7;
    localparam logic [ALUC_W-1:0] ALU_NOR = 4'd12;

    // Memory / writeback control bundle passed downstream
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_CTRL_NONE = '0;

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding mux for one source register.
// Ports:
//   src_reg_i                 operand register number
//   latched_i                 value latched from the register file
//   exmem_* / memwb_*         producer write-enable, destination, result
//   fwd_value_o               selected operand (combinational)
// EX/MEM has priority over MEM/WB; register 0 is never forwarded.
module forward_unit
    import mips_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic [REG_W-1:0]  src_reg_i,
    input  logic [DATA_W-1:0] latched_i,
    input  logic              exmem_reg_write_i,
    input  logic [REG_W-1:0]  exmem_dest_i,
    input  logic [DATA_W-1:0] exmem_result_i,
    input  logic              memwb_reg_write_i,
    input  logic [REG_W-1:0]  memwb_dest_i,
    input  logic [DATA_W-1:0] memwb_result_i,
    output logic [DATA_W-1:0] fwd_value_o
);

    logic exmem_hit;
    logic memwb_hit;

    // Producer match and priority select
    always_comb begin
        exmem_hit   = exmem_reg_write_i && (exmem_dest_i != '0) && (exmem_dest_i == src_reg_i);
        memwb_hit   = memwb_reg_write_i && (memwb_dest_i != '0) && (memwb_dest_i == src_reg_i);
        fwd_value_o = latched_i;
        if (FWD_EN) begin
            if (exmem_hit) begin
                fwd_value_o = exmem_result_i;
            end else if (memwb_hit) begin
                fwd_value_o = memwb_result_i;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Latches decoded operands/control at the end of ID and drives the ALU
// operands, ALU control and downstream memory/writeback control in EX.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   stall, flush                   external hold / squash incoming instr
//   id_*                           decoded instruction from ID
//   exmem_*, memwb_*               forwarding sources
//   hazard_stall                   load-use hazard, IF/ID must hold
//   ex_valid, alu_in1/2, alu_control, ex_store_data, ex_dest, ex_* ctrl
module id_ex_stage
    import mips_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_dest,
    input  logic [ALUC_W-1:0] id_alu_control,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              exmem_reg_write,
    input  logic [REG_W-1:0]  exmem_dest,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_W-1:0]  memwb_dest,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              hazard_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [ALUC_W-1:0] alu_control,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_W-1:0]  ex_dest,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg
);

    logic              valid_q,    valid_d;
    logic [DATA_W-1:0] rd1_q,      rd1_d;
    logic [DATA_W-1:0] rd2_q,      rd2_d;
    logic [DATA_W-1:0] imm_q,      imm_d;
    logic [REG_W-1:0]  rs_q,       rs_d;
    logic [REG_W-1:0]  rt_q,       rt_d;
    logic [REG_W-1:0]  dest_q,     dest_d;
    logic [ALUC_W-1:0] alu_ctrl_q, alu_ctrl_d;
    logic              alu_src_q,  alu_src_d;
    ex_ctrl_t          ctrl_q,     ctrl_d;

    logic [DATA_W-1:0] fwd1;
    logic [DATA_W-1:0] fwd2;

    forward_unit #(.FWD_EN(FWD_EN)) u_fwd_rs (
        .src_reg_i         (rs_q),
        .latched_i         (rd1_q),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_dest_i      (exmem_dest),
        .exmem_result_i    (exmem_result),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_dest_i      (memwb_dest),
        .memwb_result_i    (memwb_result),
        .fwd_value_o       (fwd1)
    );

    forward_unit #(.FWD_EN(FWD_EN)) u_fwd_rt (
        .src_reg_i         (rt_q),
        .latched_i         (rd2_q),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_dest_i      (exmem_dest),
        .exmem_result_i    (exmem_result),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_dest_i      (memwb_dest),
        .memwb_result_i    (memwb_result),
        .fwd_value_o       (fwd2)
    );

    // Load in EX whose destination is read by the instruction in ID
    assign hazard_stall = valid_q && ctrl_q.mem_read && (dest_q != '0) && id_valid
                          && ((dest_q == id_rs) || (dest_q == id_rt));

    // Next-state: flush > stall (hold + refresh operands) > hazard bubble > load
    always_comb begin
        valid_d    = valid_q;
        rd1_d      = rd1_q;
        rd2_d      = rd2_q;
        imm_d      = imm_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        dest_d     = dest_q;
        alu_ctrl_d = alu_ctrl_q;
        alu_src_d  = alu_src_q;
        ctrl_d     = ctrl_q;
        if (flush || (!stall && hazard_stall)) begin
            valid_d    = 1'b0;
            rd1_d      = '0;
            rd2_d      = '0;
            imm_d      = '0;
            rs_d       = '0;
            rt_d       = '0;
            dest_d     = '0;
            alu_ctrl_d = '0;
            alu_src_d  = 1'b0;
            ctrl_d     = EX_CTRL_NONE;
        end else if (stall) begin
            // Capture producers that retire while we are held
            rd1_d = fwd1;
            rd2_d = fwd2;
        end else begin
            valid_d           = id_valid;
            rd1_d             = id_rd1;
            rd2_d             = id_rd2;
            imm_d             = id_imm;
            rs_d              = id_rs;
            rt_d              = id_rt;
            dest_d            = id_dest;
            alu_ctrl_d        = id_alu_control;
            alu_src_d         = id_alu_src;
            ctrl_d.reg_write  = id_reg_write;
            ctrl_d.mem_read   = id_mem_read;
            ctrl_d.mem_write  = id_mem_write;
            ctrl_d.mem_to_reg = id_mem_to_reg;
        end
    end

    // Instruction slot register
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            dest_q     <= '0;
            alu_ctrl_q <= '0;
            alu_src_q  <= 1'b0;
            ctrl_q     <= EX_CTRL_NONE;
        end else begin
            valid_q    <= valid_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            imm_q      <= imm_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            dest_q     <= dest_d;
            alu_ctrl_q <= alu_ctrl_d;
            alu_src_q  <= alu_src_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign ex_valid      = valid_q;
    assign alu_in1       = fwd1;
    assign alu_in2       = alu_src_q ? imm_q : fwd2;
    assign alu_control   = alu_ctrl_q;
    assign ex_store_data = fwd2;
    assign ex_dest       = dest_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed test-plan scenarios plus
// random traffic compared every cycle against a behavioural slot model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [31:0] id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic [3:0]  id_alu_control;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_dest, memwb_dest;
    logic [31:0] exmem_result, memwb_result;
    logic        hazard_stall, ex_valid;
    logic [31:0] alu_in1, alu_in2, ex_store_data;
    logic [3:0]  alu_control;
    logic [4:0]  ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.FWD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
        .id_alu_control(id_alu_control), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_dest(memwb_dest), .memwb_result(memwb_result),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
    );

    // Reference model: the instruction currently held in EX
    typedef struct {
        logic        valid;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs, rt, dest;
        logic [3:0]  alu_ctrl;
        logic        alu_src, rw, mr, mw, m2r;
    } slot_t;

    slot_t m;

    function automatic slot_t bubble();
        slot_t b;
        b.valid = 1'b0; b.rd1 = '0; b.rd2 = '0; b.imm = '0;
        b.rs = '0; b.rt = '0; b.dest = '0; b.alu_ctrl = '0;
        b.alu_src = 1'b0; b.rw = 1'b0; b.mr = 1'b0; b.mw = 1'b0; b.m2r = 1'b0;
        return b;
    endfunction

    // Value the ALU sees for a register given the live producers
    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] latched);
        if (r == 5'd0) return latched;
        if (exmem_reg_write && exmem_dest == r) return exmem_result;
        if (memwb_reg_write && memwb_dest == r) return memwb_result;
        return latched;
    endfunction

    function automatic logic exp_hazard();
        return m.valid && m.mr && (m.dest != 5'd0) && id_valid
               && (m.dest == id_rs || m.dest == id_rt);
    endfunction

    function automatic slot_t model_next();
        slot_t n;
        if (rst || flush) begin
            n = bubble();
        end else if (stall) begin
            n = m;
            n.rd1 = fwd(m.rs, m.rd1);
            n.rd2 = fwd(m.rt, m.rd2);
        end else if (exp_hazard()) begin
            n = bubble();
        end else begin
            n.valid = id_valid; n.rd1 = id_rd1; n.rd2 = id_rd2; n.imm = id_imm;
            n.rs = id_rs; n.rt = id_rt; n.dest = id_dest; n.alu_ctrl = id_alu_control;
            n.alu_src = id_alu_src; n.rw = id_reg_write; n.mr = id_mem_read;
            n.mw = id_mem_write; n.m2r = id_mem_to_reg;
        end
        return n;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [31:0] f2;
        f2 = fwd(m.rt, m.rd2);
        check_val("hazard_stall", 32'(hazard_stall), 32'(exp_hazard()));
        check_val("ex_valid", 32'(ex_valid), 32'(m.valid));
        check_val("alu_in1", alu_in1, fwd(m.rs, m.rd1));
        check_val("alu_in2", alu_in2, m.alu_src ? m.imm : f2);
        check_val("store_data", ex_store_data, f2);
        check_val("alu_control", 32'(alu_control), 32'(m.alu_ctrl));
        check_val("ex_dest", 32'(ex_dest), 32'(m.dest));
        check_val("ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}),
                  32'({m.rw, m.mr, m.mw, m.m2r}));
    endtask

    // Check outputs mid-cycle, then advance one edge with the model
    task automatic cycle();
        slot_t n;
        @(negedge clk);
        compare_all();
        n = model_next();
        @(posedge clk);
        m = n;
        #1;
    endtask

    task automatic clear_inputs();
        rst = 1'b0; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_rd1 = '0; id_rd2 = '0; id_imm = '0; id_rs = '0; id_rt = '0; id_dest = '0;
        id_alu_control = '0; id_alu_src = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        id_mem_write = 1'b0; id_mem_to_reg = 1'b0;
        exmem_reg_write = 1'b0; exmem_dest = '0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_dest = '0; memwb_result = '0;
    endtask

    task automatic load_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest,
                           input logic [31:0] rd1, input logic [31:0] rd2);
        id_valid = 1'b1; id_rs = rs; id_rt = rt; id_dest = dest; id_rd1 = rd1; id_rd2 = rd2;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m = bubble();
        check_val("rst_valid", 32'(ex_valid), 32'd0);
        check_val("rst_in1", alu_in1, 32'd0);
        check_val("rst_in2", alu_in2, 32'd0);
        check_val("rst_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, alu_control}), 32'd0);
        check_val("rst_hazard", 32'(hazard_stall), 32'd0);
        rst = 1'b0;

        // Plain load
        load_id(5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        id_alu_control = 4'd2; id_reg_write = 1'b1;
        cycle();
        check_val("plain_in1", alu_in1, 32'd5);
        check_val("plain_in2", alu_in2, 32'd7);
        check_val("plain_aluc", 32'(alu_control), 32'd2);
        check_val("plain_valid", 32'(ex_valid), 32'd1);

        // Forward priority
        load_id(5'd3, 5'd2, 5'd8, 32'h11, 32'h22);
        cycle();
        exmem_reg_write = 1'b1; exmem_dest = 5'd3; exmem_result = 32'hAAAA;
        memwb_reg_write = 1'b1; memwb_dest = 5'd3; memwb_result = 32'h5555;
        #1 check_val("fwd_exmem_wins", alu_in1, 32'hAAAA);
        exmem_reg_write = 1'b0;
        #1 check_val("fwd_memwb", alu_in1, 32'h5555);
        exmem_reg_write = 1'b1; exmem_dest = 5'd0; memwb_dest = 5'd0;
        #1 check_val("fwd_r0_latched", alu_in1, 32'h11);
        clear_inputs();

        // Load-use hazard
        load_id(5'd0, 5'd0, 5'd4, 32'd0, 32'd0);
        id_mem_read = 1'b1; id_reg_write = 1'b1; id_mem_to_reg = 1'b1;
        cycle();
        load_id(5'd4, 5'd5, 5'd6, 32'hDEAD, 32'h55);
        id_mem_read = 1'b0; id_mem_to_reg = 1'b0;
        #1 check_val("lu_hazard", 32'(hazard_stall), 32'd1);
        cycle();
        check_val("lu_bubble_valid", 32'(ex_valid), 32'd0);
        check_val("lu_bubble_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}), 32'd0);
        check_val("lu_hazard_drop", 32'(hazard_stall), 32'd0);
        memwb_reg_write = 1'b1; memwb_dest = 5'd4; memwb_result = 32'hBEEF;
        cycle();
        check_val("lu_dep_valid", 32'(ex_valid), 32'd1);
        check_val("lu_dep_fwd", alu_in1, 32'hBEEF);
        clear_inputs();

        // Stall refresh
        load_id(5'd1, 5'd7, 5'd9, 32'd1, 32'd0);
        id_mem_write = 1'b1;
        cycle();
        stall = 1'b1;
        memwb_reg_write = 1'b1; memwb_dest = 5'd7; memwb_result = 32'h1234;
        load_id(5'd2, 5'd3, 5'd10, 32'hF0, 32'hF1);
        cycle();
        memwb_reg_write = 1'b0; memwb_result = 32'h0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_val("stall_refresh", ex_store_data, 32'h1234);
        end

        // Flush beats stall; reset mid-stall clears
        flush = 1'b1;
        cycle();
        check_val("flush_valid", 32'(ex_valid), 32'd0);
        check_val("flush_dest_aluc", 32'({ex_dest, alu_control}), 32'd0);
        clear_inputs();
        load_id(5'd5, 5'd6, 5'd7, 32'h77, 32'h88);
        id_alu_control = 4'd6; id_reg_write = 1'b1;
        cycle();
        stall = 1'b1;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0; stall = 1'b0; id_valid = 1'b0;
        check_val("rst_stall_valid", 32'(ex_valid), 32'd0);
        check_val("rst_stall_data", alu_in1 | alu_in2 | ex_store_data, 32'd0);
        check_val("rst_stall_ctrl", 32'({ex_dest, alu_control, ex_reg_write}), 32'd0);

        // Immediate path
        clear_inputs();
        load_id(5'd1, 5'd9, 5'd2, 32'd0, 32'd0);
        id_alu_src = 1'b1; id_imm = 32'hFFFF_FFFC;
        cycle();
        exmem_reg_write = 1'b1; exmem_dest = 5'd9; exmem_result = 32'h99;
        #1;
        check_val("imm_in2", alu_in2, 32'hFFFF_FFFC);
        check_val("imm_store", ex_store_data, 32'h99);
        cycle();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst             = ($urandom_range(0, 99) < 2);
            stall           = ($urandom_range(0, 99) < 20);
            flush           = ($urandom_range(0, 99) < 10);
            id_valid        = ($urandom_range(0, 99) < 85);
            id_rd1          = $urandom;
            id_rd2          = $urandom;
            id_imm          = $urandom;
            id_rs           = 5'($urandom_range(0, 7));
            id_rt           = 5'($urandom_range(0, 7));
            id_dest         = 5'($urandom_range(0, 7));
            id_alu_control  = 4'($urandom);
            id_alu_src      = 1'($urandom);
            id_reg_write    = 1'($urandom);
            id_mem_read     = ($urandom_range(0, 99) < 35);
            id_mem_write    = 1'($urandom);
            id_mem_to_reg   = 1'($urandom);
            exmem_reg_write = 1'($urandom);
            exmem_dest      = 5'($urandom_range(0, 7));
            exmem_result    = $urandom;
            memwb_reg_write = 1'($urandom);
            memwb_dest      = 5'($urandom_range(0, 7));
            memwb_result    = $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
